// File: rtl/trig_cfg_pkg.sv
// trig_cfg_pkg: opcode classes, control codes and FSM state type shared by the
// trigger configuration loader.
package trig_cfg_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_ALL = 2'b10;
    localparam logic [1:0] OP_CTL = 2'b11;

    localparam logic [7:0] CTL_CLEAR  = 8'hC0;
    localparam logic [7:0] CTL_ARM    = 8'hC1;
    localparam logic [7:0] CTL_DISARM = 8'hC2;
    localparam logic [7:0] CTL_ERRCLR = 8'hC3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARG   = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic [1:0] op_class(input logic [7:0] b);
        return b[7:6];
    endfunction

endpackage

// File: rtl/trig_cfg_loader_if.sv
// trig_cfg_loader_if: host byte stream (valid/ready) into the trigger config loader.
interface trig_cfg_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/trig_cfg_timer.sv
// trig_cfg_timer: loadable down-counter flagging expiry after LOAD cycles of running.
// Only present when TRIG_CFG_TIMEOUT_EN is defined.
`ifdef TRIG_CFG_TIMEOUT_EN
module trig_cfg_timer #(
    parameter int unsigned LOAD = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);
    localparam int W = (LOAD > 1) ? $clog2(LOAD) : 1;

    logic [W-1:0] r_cnt;

    // Loaded with LOAD-1 so expiry is seen in the LOAD-th running cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(LOAD - 1);
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = i_run && (r_cnt == '0);
endmodule
`endif

// File: rtl/trig_cfg_loader.sv
// trig_cfg_loader: decodes host config bytes into trigger-cell writes, enable and clear.
// Optional argument-byte timeout under `TRIG_CFG_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ARG   | SET/ALL opcode seen, waiting for its argument byte
// WRITE | wcmd/wen presented to the trigger cells for one cycle
module trig_cfg_loader
    import trig_cfg_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RST_N,
    trig_cfg_loader_if.slave rx,
    output logic [3:0]       wcmd,
    output logic [NCH-1:0]   wen,
    output logic             set_init,
    output logic             en,
    output logic             err,
    output logic             busy
);

    state_t           r_state;
    logic             r_rx_ready;
    logic [3:0]       r_wcmd;
    logic [NCH-1:0]   r_wen;
    logic             r_set_init;
    logic             r_en;
    logic             r_err;
    logic             r_busy;
    logic [5:0]       r_chan;
    logic             r_all;
    logic             r_chan_bad;

    logic             w_accept;
    logic [NCH-1:0]   w_onehot;

    assign w_accept = rx.rx_valid && r_rx_ready;
    assign w_onehot = NCH'(1) << r_chan;

`ifdef TRIG_CFG_TIMEOUT_EN
    logic w_timeout;

    trig_cfg_timer #(
        .LOAD (TIMEOUT)
    ) u_timer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_load    (w_accept),
        .i_run     (r_state == ARG),
        .o_expired (w_timeout)
    );
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_rx_ready <= 1'b1;
            r_wcmd     <= 4'h0;
            r_wen      <= '0;
            r_set_init <= 1'b0;
            r_en       <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_chan     <= 6'd0;
            r_all      <= 1'b0;
            r_chan_bad <= 1'b0;
        end else begin
            r_wen      <= '0;
            r_set_init <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (op_class(rx.rx_data))
                            OP_NOP: ;
                            OP_SET: begin
                                r_chan     <= rx.rx_data[5:0];
                                r_all      <= 1'b0;
                                r_chan_bad <= 32'(rx.rx_data[5:0]) >= 32'(NCH);
                                r_state    <= ARG;
                                r_busy     <= 1'b1;
                            end
                            OP_ALL: begin
                                r_all      <= 1'b1;
                                r_chan_bad <= 1'b0;
                                r_state    <= ARG;
                                r_busy     <= 1'b1;
                            end
                            OP_CTL: begin
                                case (rx.rx_data)
                                    CTL_CLEAR: begin
                                        r_set_init <= 1'b1;
                                        r_en       <= 1'b0;
                                    end
                                    CTL_ARM:    r_en  <= 1'b1;
                                    CTL_DISARM: r_en  <= 1'b0;
                                    CTL_ERRCLR: r_err <= 1'b0;
                                    default:    r_err <= 1'b1;
                                endcase
                            end
                        endcase
                    end
                end
                ARG: begin
                    // Bad argument or out-of-range channel: byte consumed, nothing written.
                    if (w_accept) begin
                        if ((rx.rx_data[7:4] != 4'h0) || r_chan_bad) begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_wcmd     <= rx.rx_data[3:0];
                            r_wen      <= r_all ? '1 : w_onehot;
                            r_state    <= WRITE;
                            r_rx_ready <= 1'b0;
                        end
                    end
`ifdef TRIG_CFG_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
`endif
                end
                WRITE: begin
                    r_state    <= IDLE;
                    r_rx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_rx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_ready = r_rx_ready;
    assign wcmd        = r_wcmd;
    assign wen         = r_wen;
    assign set_init    = r_set_init;
    assign en          = r_en;
    assign err         = r_err;
    assign busy        = r_busy;

endmodule

// File: doc/trig_cfg_loader.md
# trig_cfg_loader

Host-side configuration writer for the per-channel trigger cells of the logic analyzer. Consumes a byte stream from the host link (valid/ready), decodes trigger-configuration commands, and drives the shared 4-bit trigger command bus with one-hot per-channel write strobes. It also drives the global trigger enable and the configuration-clear pulse. It sits between the host byte receiver and the array of NCH trigger cells.

## Interface
- NCH, 8: number of trigger channels; legal range 1..64.
- TIMEOUT, 1024: argument-byte timeout in CLK cycles; used only with TRIG_CFG_TIMEOUT_EN.
- CLK  input  1  system clock; all logic on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- rx_data  input  8  host command/argument byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  byte accepted when rx_valid && rx_ready.
- wcmd  output  4  shared trigger command bus: [3] channel enable, [1:0] level/edge code.
- wen  output  NCH  one-hot write strobe, one per trigger cell.
- set_init  output  1  one-cycle pulse that clears all trigger cells' CMD.
- en  output  1  global trigger enable.
- err  output  1  sticky protocol-error flag.
- busy  output  1  high when not in IDLE.

## Operation
- Opcode byte, top two bits:
  - 00xxxxxx: NOP.
  - 01cccccc: SET channel c; expects one argument byte.
  - 10xxxxxx: ALL; expects one argument byte, broadcast to every channel.
  - 11xxxxxx: control:
    - 0xC0 CLEAR: set_init pulse, en←0.
    - 0xC1 ARM: en←1.
    - 0xC2 DISARM: en←0.
    - 0xC3 ERRCLR: err←0.
    - 0xC4–0xFF: err←1, otherwise ignored.
- Argument byte: low nibble is the CMD value. A nonzero upper nibble sets err and aborts the write: no wen, return to IDLE.
- SET with c ≥ NCH: the argument is still consumed, err←1, no wen.
- States and transitions:
  - IDLE: accepts opcode; SET/ALL → ARG.
  - ARG: accepts argument; valid → WRITE, invalid → IDLE.
  - WRITE: wcmd driven and wen asserted for exactly one cycle → IDLE.
- rx_ready = 1 in IDLE and ARG, 0 in WRITE.
- wcmd holds its last written value between writes.
- wen and set_init are never asserted in the same cycle.
- ARM while armed and DISARM while disarmed are no-ops.
- SET/ALL do not change en.
- err sets on any error and clears only via ERRCLR or reset. A simultaneous set and ERRCLR in the same cycle is impossible, since each byte carries one command.

## Timing
- Reset values: state IDLE, rx_ready 1, wcmd 0, wen 0, set_init 0, en 0, err 0, busy 0.
- SET/ALL: argument accepted at edge M; wcmd and wen valid in cycle M+1; wen low at M+2. Minimum 3 cycles per SET/ALL command.
- Control opcode accepted at edge N: en/err/set_init update in cycle N+1; set_init is exactly one cycle wide.
- Back-to-back commands: the next opcode is accepted the cycle after WRITE.
- Reset mid-command (any state): immediately returns to reset values; a partial command is discarded with no wen.

## Configuration
- TRIG_CFG_TIMEOUT_EN defined:
  - A counter runs in ARG and resets on each accepted byte.
  - Reaching TIMEOUT cycles without an argument sets err and returns to IDLE, with no wen.
- Not defined: ARG waits indefinitely, and the TIMEOUT parameter is unused.

## Structure
- Package trig_cfg_pkg: opcode class constants (OP_NOP, OP_SET, OP_ALL, OP_CTL), control codes (CTL_CLEAR, CTL_ARM, CTL_DISARM, CTL_ERRCLR), state enum (IDLE, ARG, WRITE).
- One sub-module, trig_cfg_timer: loadable down-counter with an expiry flag, instantiated only under TRIG_CFG_TIMEOUT_EN.

## Test plan
- Reset, then bytes 0x43, 0x0D → wcmd=0xD, wen=8'b0000_1000 for one cycle, err=0.
- 0x80, 0x09 with NCH=8 → wen=8'hFF for one cycle, wcmd=0x9.
- 0x4A, 0x05 → argument consumed, err=1, wen stays 0. Then 0xC3 → err=0.
- 0xC1 → en=1. Then 0xC0 → set_init high for exactly one cycle, en=0.
- 0x41, 0x3C → err=1, no wen. Drop RST_N during ARG after 0x42 → all outputs at reset values, no wen.
- With TRIG_CFG_TIMEOUT_EN and TIMEOUT=16: 0x40 then idle for 16 cycles → err=1, busy=0. The next byte 0x05 is treated as an opcode (NOP), with no write.
